// File: rtl/station_dock_ctrl.sv
// Docking controller: confirms a station from stable IR side flags, slows, stops, dwells, then departs.
// Optional STATION_DOCK_COUNT_EN implements the 8-bit station_count register; otherwise it is tied to 0.
module station_dock_ctrl #(
    parameter int CONFIRM_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int BLANK_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       proximity,
    input  logic [1:0] dist_state,
    input  logic       resume,
    output logic       slow,
    output logic       stop,
    output logic       docked,
    output logic [1:0] side,
    output logic       fault,
    output logic [7:0] station_count
);
    localparam int HOLD_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CW-1:0] CONF_LAST  = CW'(CONFIRM_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] DWELL_LAST = HW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] BLANK_LAST = HW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRUISE, S_APPROACH, S_DOCKED, S_DEPART, S_FAULT
    } state_t;

    state_t        state, next_state;
    logic [1:0]    prev_ds;
    logic [CW-1:0] conf_cnt, conf_inc;
    logic [TW-1:0] tmo_cnt;
    logic [HW-1:0] hold_cnt;
    logic          ds_stable, conf_hit, tmo_hit, dwell_hit, blank_hit, dock_entry;
    logic          slow_d, stop_d, docked_d, fault_d;

    assign ds_stable  = (dist_state != 2'b00) && (dist_state == prev_ds);
    assign conf_inc   = conf_cnt + CW'(1);
    // Confirm fires on the edge where the count would reach its last value, not one edge later.
    assign conf_hit   = ds_stable && (conf_inc == CONF_LAST);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign dwell_hit  = (hold_cnt == DWELL_LAST);
    assign blank_hit  = (hold_cnt == BLANK_LAST);
    assign dock_entry = (state == S_APPROACH) && (next_state == S_DOCKED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:     if (enable) next_state = S_CRUISE;
            S_CRUISE:   if (proximity) next_state = S_APPROACH;
            S_APPROACH: begin
                if (conf_hit)     next_state = (dist_state == 2'b11) ? S_FAULT : S_DOCKED;
                else if (tmo_hit) next_state = S_CRUISE;
            end
            S_DOCKED:   if (resume || dwell_hit) next_state = S_DEPART;
            S_DEPART:   if (blank_hit) next_state = S_CRUISE;
            S_FAULT:    next_state = S_FAULT;
            default:    next_state = S_IDLE;
        endcase
        if (!enable && state != S_FAULT) next_state = S_IDLE;
    end

    // Counters only advance while staying in their state, so any entry or exit clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ds  <= 2'b00;
            conf_cnt <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            prev_ds <= dist_state;
            if (state == S_APPROACH && next_state == S_APPROACH) begin
                conf_cnt <= ds_stable ? conf_inc : '0;
                tmo_cnt  <= tmo_cnt + TW'(1);
            end else begin
                conf_cnt <= '0;
                tmo_cnt  <= '0;
            end
            if (next_state == state && (state == S_DOCKED || state == S_DEPART))
                hold_cnt <= hold_cnt + HW'(1);
            else
                hold_cnt <= '0;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slow_d   = 1'b0;
        stop_d   = 1'b0;
        docked_d = 1'b0;
        fault_d  = 1'b0;
        unique case (state)
            S_IDLE:     stop_d = 1'b1;
            S_APPROACH: slow_d = 1'b1;
            S_DOCKED: begin
                stop_d   = 1'b1;
                docked_d = 1'b1;
            end
            S_FAULT: begin
                stop_d  = 1'b1;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slow   <= 1'b0;
            stop   <= 1'b1;
            docked <= 1'b0;
            fault  <= 1'b0;
            side   <= 2'b00;
        end else begin
            slow   <= slow_d;
            stop   <= stop_d;
            docked <= docked_d;
            fault  <= fault | fault_d;
            if (dock_entry) side <= dist_state;
        end
    end

`ifdef STATION_DOCK_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)             station_count <= 8'd0;
        else if (dock_entry) station_count <= station_count + 8'd1;
    end
`else
    assign station_count = 8'd0;
`endif

endmodule

// File: tb/tb_station_dock_ctrl.sv
// Directed bench for station_dock_ctrl with small timing parameters; inputs driven and outputs
// sampled on the falling edge, edge numbers in comments count rising edges after reset release.
module tb_station_dock_ctrl;
    logic       clk = 1'b0;
    logic       rst, enable, proximity, resume;
    logic [1:0] dist_state;
    logic       slow, stop, docked, fault;
    logic [1:0] side;
    logic [7:0] station_count;

    int checks = 0;
    int errors = 0;

`ifdef STATION_DOCK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    station_dock_ctrl #(
        .CONFIRM_CYCLES(4),
        .TIMEOUT_CYCLES(20),
        .DWELL_CYCLES  (10),
        .BLANK_CYCLES  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .proximity    (proximity),
        .dist_state   (dist_state),
        .resume       (resume),
        .slow         (slow),
        .stop         (stop),
        .docked       (docked),
        .side         (side),
        .fault        (fault),
        .station_count(station_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        return CNT_EN ? 8'(n) : 8'd0;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; proximity = 1'b0; resume = 1'b0; dist_state = 2'b00;
        cyc(2);
        check("rst_slow", slow, 0);
        check("rst_stop", stop, 1);
        check("rst_docked", docked, 0);
        check("rst_side", side, 0);
        check("rst_fault", fault, 0);
        check("rst_count", station_count, 0);

        // Normal dock
        rst = 1'b0; enable = 1'b1;
        cyc(1);                                   // e1: IDLE -> CRUISE
        check("idle_stop", stop, 1);
        cyc(1);                                   // e2
        check("cruise_stop", stop, 0);
        check("cruise_slow", slow, 0);
        proximity = 1'b1; dist_state = 2'b01;
        cyc(1);                                   // e3: -> APPROACH
        proximity = 1'b0;
        check("prox_latency", slow, 0);
        cyc(1);                                   // e4
        check("approach_slow", slow, 1);
        cyc(2);                                   // e6: confirm -> DOCKED
        check("confirm_docked_lag", docked, 0);
        check("confirm_side", side, 2'b01);
        check("confirm_count", station_count, exp_cnt(1));
        cyc(1);                                   // e7
        check("docked", docked, 1);
        check("docked_stop", stop, 1);
        check("docked_slow", slow, 0);
        dist_state = 2'b00;
        cyc(9);                                   // e16: dwell expires -> DEPART
        check("dwell_last", docked, 1);
        cyc(1);                                   // e17
        check("depart_docked", docked, 0);
        check("depart_stop", stop, 0);
        cyc(4);                                   // e21
        proximity = 1'b1;
        cyc(1);                                   // e22: last DEPART edge, pulse ignored
        proximity = 1'b0;
        cyc(1);                                   // e23
        check("blank_last_edge", slow, 0);
        proximity = 1'b1;
        cyc(1);                                   // e24: CRUISE accepts pulse
        proximity = 1'b0;

        // Glitch rejection, then timeout
        for (int i = 0; i < 20; i++) begin
            dist_state = ((i / 2) % 2 == 0) ? 2'b01 : 2'b00;
            cyc(1);                               // e25..e44
            if (i == 0) check("recruise_slow", slow, 1);
        end
        check("glitch_no_dock", docked, 0);
        check("timeout_last", slow, 1);
        cyc(1);                                   // e45
        check("timeout_cruise", slow, 0);
        check("timeout_count", station_count, exp_cnt(1));
        check("timeout_side", side, 2'b01);

        // Early resume and blanking
        proximity = 1'b1; dist_state = 2'b10;
        cyc(1);                                   // e46: -> APPROACH
        cyc(1);                                   // e47: pulse in APPROACH ignored
        proximity = 1'b0;
        cyc(2);                                   // e49: -> DOCKED
        check("dock2_side", side, 2'b10);
        check("dock2_count", station_count, exp_cnt(2));
        cyc(1);                                   // e50
        check("dock2_docked", docked, 1);
        dist_state = 2'b00; resume = 1'b1;
        cyc(1);                                   // e51: dwell cycle 2 -> DEPART
        resume = 1'b0;
        check("resume_lag", docked, 1);
        cyc(1);                                   // e52
        check("resume_depart", docked, 0);
        check("resume_stop", stop, 0);
        proximity = 1'b1;
        cyc(1);                                   // e53: ignored in DEPART
        proximity = 1'b0;
        cyc(1);                                   // e54
        check("depart_prox_ignored", slow, 0);

        // enable=0 during APPROACH
        cyc(3);                                   // e57: -> CRUISE
        proximity = 1'b1; dist_state = 2'b01;
        cyc(1);                                   // e58
        proximity = 1'b0;
        cyc(1);                                   // e59
        check("d_approach_slow", slow, 1);
        enable = 1'b0;
        cyc(1);                                   // e60: -> IDLE
        cyc(1);                                   // e61
        check("disable_stop", stop, 1);
        check("disable_slow", slow, 0);
        check("disable_side", side, 2'b10);
        check("disable_count", station_count, exp_cnt(2));

        // rst during DOCKED
        enable = 1'b1;
        cyc(1);                                   // e62
        proximity = 1'b1;
        cyc(1);                                   // e63
        proximity = 1'b0;
        cyc(3);                                   // e66: -> DOCKED
        cyc(1);                                   // e67
        check("dock3_docked", docked, 1);
        check("dock3_count", station_count, exp_cnt(3));
        rst = 1'b1;
        cyc(1);                                   // e68
        check("mid_rst_docked", docked, 0);
        check("mid_rst_count", station_count, 0);
        check("mid_rst_side", side, 0);
        check("mid_rst_stop", stop, 1);

        // Fault on both sides
        rst = 1'b0;
        cyc(1);                                   // e69: -> CRUISE
        proximity = 1'b1; dist_state = 2'b11;
        cyc(1);                                   // e70
        proximity = 1'b0;
        cyc(3);                                   // e73: -> FAULT
        check("fault_lag", fault, 0);
        cyc(1);                                   // e74
        check("fault", fault, 1);
        check("fault_stop", stop, 1);
        check("fault_docked", docked, 0);
        check("fault_side", side, 0);
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(2);
        check("fault_enable_stop", stop, 1);
        check("fault_enable_fault", fault, 1);
        check("fault_enable_slow", slow, 0);
        rst = 1'b1;
        cyc(1);
        check("fault_rst_fault", fault, 0);
        check("fault_rst_stop", stop, 1);
        rst = 1'b0; enable = 1'b0; dist_state = 2'b00;
        cyc(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
